// File: rtl/pixel_streamer.sv
// Frame buffer plus raster-order streamer feeding the layer-1 conv/pool pipeline.
// Optional zero-pad border: define PAD_EN to emit a (W+2*PAD) x (H+2*PAD) frame.
module pixel_streamer #(
  parameter int PP  = 8,
  parameter int W   = 32,
  parameter int H   = 32,
  parameter int PAD = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(W*H)-1:0]      wr_addr,
  input  logic signed [PP:0]          wr_data,
  input  logic                        start,
  output logic signed [PP:0]          pxl_out,
  output logic                        pxl_valid,
  output logic                        sof,
  output logic                        eol,
  output logic                        eof,
  output logic                        busy,
  output logic                        wr_err
);

  localparam int DEPTH = W * H;
  localparam int AW    = $clog2(DEPTH);
`ifdef PAD_EN
  localparam int EP = PAD;
`else
  // PAD has no effect without the border feature.
  localparam int EP = 0 * PAD;
`endif
  localparam int FW = W + 2 * EP;
  localparam int FH = H + 2 * EP;
  localparam int CW = $clog2(FW + 1);
  localparam int RW = $clog2(FH + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  int                    w_row_i;
  int                    w_col_i;
  logic                  w_last;
  logic                  w_issue;
  logic                  w_sof;
  logic                  w_eol;
  logic                  w_eof;
  logic                  w_pad;
  logic                  w_busy_nxt;
  logic [AW-1:0]         w_rd_addr;
  logic                  w_wr_ok;

  logic signed [PP:0]    r_mem [DEPTH];
  logic signed [PP:0]    r_rd_data;
  logic                  r_v1;
  logic                  r_sof1;
  logic                  r_eol1;
  logic                  r_eof1;
  logic                  r_pad1;

  logic signed [PP:0]    r_pxl_out;
  logic                  r_pxl_valid;
  logic                  r_sof;
  logic                  r_eol;
  logic                  r_eof;
  logic                  r_busy;
  logic                  r_wr_err;

  assign w_row_i = int'(r_row);
  assign w_col_i = int'(r_col);
  assign w_last  = (w_row_i == FH - 1) && (w_col_i == FW - 1);

`ifdef PAD_EN
  assign w_pad = (w_row_i < EP) || (w_row_i >= H + EP) ||
                 (w_col_i < EP) || (w_col_i >= W + EP);
`else
  assign w_pad = 1'b0;
`endif

  assign w_rd_addr = w_pad ? {AW{1'b0}} : AW'((w_row_i - EP) * W + (w_col_i - EP));
  assign w_wr_ok   = wr_en && !r_busy && (32'(wr_addr) < DEPTH_U);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_last ? S_DRAIN : S_STREAM;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_last) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_STREAM;
        end
      end
      S_DRAIN: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: read issue and the framing strobes travelling with it
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      S_IDLE:   w_issue = start;
      S_STREAM: w_issue = 1'b1;
      S_DRAIN:  w_issue = 1'b0;
      default:  w_issue = 1'b0;
    endcase
    w_sof      = w_issue && (w_row_i == 0) && (w_col_i == 0);
    w_eol      = w_issue && (w_col_i == FW - 1);
    w_eof      = w_issue && w_last;
    // Stays high through DRAIN so busy drops one edge after eof.
    w_busy_nxt = (r_state != S_IDLE) || start;
  end

  // Raster position counters; they only move when a read is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= {RW{1'b0}};
      r_col <= {CW{1'b0}};
    end else if (w_issue) begin
      if (w_col_i == FW - 1) begin
        r_col <= {CW{1'b0}};
        r_row <= (w_row_i == FH - 1) ? {RW{1'b0}} : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Frame buffer: synchronous write and synchronous read, contents not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Read-stage control pipeline aligned with r_rd_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1   <= 1'b0;
      r_sof1 <= 1'b0;
      r_eol1 <= 1'b0;
      r_eof1 <= 1'b0;
      r_pad1 <= 1'b0;
    end else begin
      r_v1   <= w_issue;
      r_sof1 <= w_sof;
      r_eol1 <= w_eol;
      r_eof1 <= w_eof;
      r_pad1 <= w_pad;
    end
  end

  // Registered outputs, busy flag and sticky write-error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pxl_out   <= {(PP+1){1'b0}};
      r_pxl_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_pxl_out   <= (r_v1 && !r_pad1) ? r_rd_data : {(PP+1){1'b0}};
      r_pxl_valid <= r_v1;
      r_sof       <= r_sof1;
      r_eol       <= r_eol1;
      r_eof       <= r_eof1;
      r_busy      <= w_busy_nxt;
      r_wr_err    <= r_wr_err || (wr_en && r_busy);
    end
  end

  assign pxl_out   = r_pxl_out;
  assign pxl_valid = r_pxl_valid;
  assign sof       = r_sof;
  assign eol       = r_eol;
  assign eof       = r_eof;
  assign busy      = r_busy;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_pixel_streamer.sv
// Randomized self-checking bench for pixel_streamer against a frame-level reference model.
module tb_pixel_streamer;

  localparam int PP = 8;
`ifdef PAD_EN
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 2;
  localparam int FW = W + 2 * P;
  localparam int FH = H + 2 * P;
`else
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int P  = 2;
  localparam int FW = W;
  localparam int FH = H;
`endif
  localparam int N     = FW * FH;
  localparam int DEPTH = W * H;
  localparam int AW    = $clog2(DEPTH);
  localparam int MID   = (N > 300) ? 300 : N / 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic signed [PP:0]  wr_data;
  logic                start;
  logic signed [PP:0]  pxl_out;
  logic                pxl_valid;
  logic                sof;
  logic                eol;
  logic                eof;
  logic                busy;
  logic                wr_err;

  int n_cmp = 0;
  int n_err = 0;
  int mdl_mem [DEPTH];

  always #5 clk = ~clk;

  pixel_streamer #(.PP(PP), .W(W), .H(H), .PAD(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .pxl_out   (pxl_out),
    .pxl_valid (pxl_valid),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .wr_err    (wr_err)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected pixel i of the emitted frame, from the buffer model and border rule
  function automatic int exp_pix(input int i);
    int r, c, pr;
    r  = i / FW;
    c  = i % FW;
    pr = (FW - W) / 2;
    if (r < pr || r >= H + pr || c < pr || c >= W + pr) return 0;
    return mdl_mem[(r - pr) * W + (c - pr)];
  endfunction

  function automatic int rand_pix();
    return int'($urandom_range(0, (2 ** (PP + 1)) - 1)) - (2 ** PP);
  endfunction

  task automatic write_px(input int a, input int v);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = (PP+1)'(v);
    @(posedge clk); #1;
    wr_en   = 1'b0;
    mdl_mem[a] = v;
  endtask

  task automatic load_frame(input int ramp);
    for (int a = 0; a < DEPTH; a++) begin
      write_px(a, ramp ? ((a % 256) - 128) : rand_pix());
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_valid"}, pxl_valid, 0);
      check({tag, "_pxl"}, pxl_out, 0);
      check({tag, "_strb"}, {sof, eol, eof}, 0);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  // Checks `count` consecutive pixels; optionally pokes a write and a start at pixel `inject`
  task automatic stream_check(input string tag, input int count, input int inject);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      if (inject >= 0 && i == inject + 1) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      check({tag, "_valid"}, pxl_valid, 1);
      check({tag, "_pxl"}, pxl_out, exp_pix(i));
      check({tag, "_sof"}, sof, (i == 0) ? 1 : 0);
      check({tag, "_eol"}, eol, (i % FW == FW - 1) ? 1 : 0);
      check({tag, "_eof"}, eof, (i == N - 1) ? 1 : 0);
      check({tag, "_busy"}, busy, 1);
      if (i == inject) begin
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = (PP+1)'(~mdl_mem[5]);
        start   = 1'b1;
      end
    end
  endtask

  task automatic do_frame(input string tag, input int inject);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_k"}, busy, 1);
    check({tag, "_valid_k"}, pxl_valid, 0);
    stream_check(tag, N, inject);
    @(posedge clk); #1;
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, pxl_valid, 0);
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = {AW{1'b0}};
    wr_data = {(PP+1){1'b0}};
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", pxl_valid, 0);
    check("rst_pxl", pxl_out, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_err", wr_err, 0);
    reset = 1'b1;
    idle_check("idle", 20);

    load_frame(1);
    do_frame("ramp", -1);

    load_frame(0);
    do_frame("rand", -1);
    check("wr_err_clean", wr_err, 0);

    do_frame("wrbusy", 100 % N);
    check("wr_err_set", wr_err, 1);
    do_frame("after_wr", -1);
    check("wr_err_sticky", wr_err, 1);

    for (int j = 0; j < 8; j++) begin
      write_px(int'($urandom_range(0, DEPTH - 1)), rand_pix());
    end
    write_px(5, rand_pix());
    do_frame("idle_wr", -1);

    start = 1'b1;
    @(posedge clk); #1;
    check("b2b_busy_k", busy, 1);
    stream_check("b2b1", N, -1);
    @(posedge clk); #1;
    check("b2b_gap_valid", pxl_valid, 0);
    check("b2b_gap_busy", busy, 1);
    start = 1'b0;
    stream_check("b2b2", N, -1);
    @(posedge clk); #1;
    check("b2b_end_busy", busy, 0);
    check("b2b_end_valid", pxl_valid, 0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream_check("mid", MID, -1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", pxl_valid, 0);
    check("mid_rst_pxl", pxl_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_err", wr_err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_check("post_rst_idle", 10);
    do_frame("post_rst", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
Frame source that drives the pixel input of the layer-1 convolution/pool pipeline. It holds one W x H signed frame in an internal buffer, loaded through a simple write port. On a start pulse it emits the frame in raster order, one pixel per clock, with valid and framing strobes. There is no backpressure: the downstream conv stage consumes every valid pixel.

Parameters:
PP, 8, MSB index of pixel data (pixel width = PP+1, signed)
W, 32, frame width in pixels
H, 32, frame height in pixels
PAD, 2, zero-pad border width in pixels (used only when PAD_EN is defined)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  $clog2(W*H)  raster-order write address (row*W + col)
wr_data  in  PP+1  signed pixel written at wr_addr
start  in  1  begin streaming one frame (sampled only in IDLE)
pxl_out  out  PP+1  signed pixel to the conv stage
pxl_valid  out  1  pxl_out holds a frame pixel this cycle
sof  out  1  high with the first pixel of the frame
eol  out  1  high with the last pixel of each row
eof  out  1  high with the last pixel of the frame
busy  out  1  high from start acceptance until the cycle after eof
wr_err  out  1  sticky; set by a write attempted while busy

Behaviour:
- Reset (reset low, asynchronous): state IDLE, row/col counters 0; pxl_out=0, pxl_valid=0, sof=eol=eof=0, busy=0, wr_err=0. Buffer contents are not reset.
- Buffer: W*H entries, synchronous write, synchronous read, 1-cycle read latency. Writes are accepted only when busy=0. A write while busy=1 is dropped and sets wr_err. wr_err clears only on reset. wr_addr >= W*H is ignored.
- FSM states:
  - IDLE: start=1 at edge k -> STREAM, busy=1 from k. Read address 0 is issued at k.
  - STREAM: one read address per cycle, col 0..W-1, then row+1. The address issued with row=H-1, col=W-1 -> DRAIN.
  - DRAIN: one cycle to flush the read pipeline -> IDLE.
- Latency: first pixel (sof=1, pxl_valid=1) is registered at edge k+1. pxl_valid is high for exactly W*H consecutive cycles with no gaps. eof coincides with the last pixel. busy falls at the edge after eof.
- Strobes: eol is high for the col=W-1 pixel; eof is high for the last pixel, with eol also high. Each strobe is asserted only when pxl_valid=1. When pxl_valid=0, pxl_out is driven to 0.
- start while busy=1 is ignored; no queuing.
- start held high continuously: a new frame is accepted in the first IDLE cycle, giving exactly one idle (pxl_valid=0) cycle between frames.
- Reset asserted mid-frame: outputs drop immediately. After release the block sits in IDLE; no partial frame resumes.
- Counters wrap only through the FSM; no free-running counter.

Optional Feature:
PAD_EN: when defined, the emitted frame is (W+2*PAD) x (H+2*PAD).
- Pixels at row<PAD, row>=H+PAD, col<PAD or col>=W+PAD are emitted as 0 with pxl_valid=1.
- Interior pixels come from the buffer at (row-PAD)*W + (col-PAD).
- sof, eol and eof refer to the padded frame. Total valid cycles = (W+2*PAD)*(H+2*PAD).
- When not defined, PAD is ignored and the frame is W x H as above.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, no start -> all outputs 0 for 20 cycles.
- Ramp frame: write value (addr mod 256)-128 to all 1024 entries, pulse start at edge k -> sof at k+1 with pxl_out=-128; 1024 contiguous valid cycles, value sequence matching; eol every 32nd pixel; eof at k+1024; busy low at k+1025.
- Write while busy: issue wr_en mid-stream at addr 5 -> buffer unchanged on the next frame, wr_err=1 until reset.
- Back-to-back: hold start high for 2 frames -> exactly 1 cycle with pxl_valid=0 between the eof of frame 1 and the sof of frame 2.
- Mid-frame reset: assert reset at pixel 300 -> pxl_valid=0 asynchronously. After release with no start -> stays IDLE. A new start -> full frame from pixel 0.
- PAD_EN, W=H=4, PAD=2: 64 valid cycles. Rows 0,1,6,7 and cols 0,1,6,7 are 0; interior equals the buffer; eol every 8 pixels.
